// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   rxd            asynchronous serial line, idles high
//   d_rx, vld_rx   head-of-FIFO byte and FIFO-not-empty
//   rdy_rx         consumer ready; a pop is vld_rx & rdy_rx
//   count          FIFO occupancy 0..2**AW
//   frame_err      sticky: a frame had a low stop bit
//   overflow       sticky: a byte was dropped on a full FIFO
//   clr_err        synchronous clear of both sticky flags
module uart_rx_buf #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 115200,
   parameter int unsigned AW       = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rxd,
   output logic [7:0]    d_rx,
   output logic          vld_rx,
   input  logic          rdy_rx,
   output logic [AW:0]   count,
   output logic          frame_err,
   output logic          overflow,
   input  logic          clr_err
);

   localparam int unsigned DIV   = CLK_FREQ / BAUD;
   localparam int unsigned CW    = $clog2(DIV);
   localparam int unsigned DEPTH = 2 ** AW;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Two-flop synchroniser, preset high so reset looks like an idle line
   logic rx_meta_q, rxs_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rxd;
         rxs_q     <= rx_meta_q;
      end
   end

   // Receive FSM; push_q is a one-cycle strobe carrying byte_q into the FIFO
   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic [7:0]      byte_q;
   logic            push_q;
   logic            frame_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         byte_q      <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (clr_err) frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rxs_q) begin
                  cnt_q   <= CW'(DIV / 2 - 1);
                  state_q <= START;
               end
            end
            START: begin
               if (cnt_q == '0) begin
                  if (rxs_q) begin
                     state_q <= IDLE;
                  end else begin
                     cnt_q   <= CW'(DIV - 1);
                     bit_q   <= '0;
                     state_q <= DATA;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            DATA: begin
               if (cnt_q == '0) begin
                  shift_q <= {rxs_q, shift_q[7:1]};
                  cnt_q   <= CW'(DIV - 1);
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            STOP: begin
               if (cnt_q == '0) begin
                  // No wait for the end of the stop bit: back-to-back frames
                  if (rxs_q) begin
                     push_q <= 1'b1;
                     byte_q <= shift_q;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // FWFT FIFO; pointers carry one extra wrap bit to separate full from empty
   logic [7:0]    mem_q [DEPTH];
   logic [AW:0]   wr_q, rd_q, wr_d, rd_d;
   logic [AW:0]   count_q;
   logic [7:0]    d_rx_q;
   logic          vld_q;
   logic          overflow_q;
   logic          full_c, pop_c, push_acc_c, drop_c;

   always_comb begin
      full_c     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop_c      = vld_q & rdy_rx;
      push_acc_c = push_q & (!full_c | pop_c);
      drop_c     = push_q & full_c & !pop_c;
      wr_d       = wr_q + (AW + 1)'(push_acc_c);
      rd_d       = rd_q + (AW + 1)'(pop_c);
   end

   always_ff @(posedge clk) begin
      if (push_acc_c) mem_q[wr_q[AW-1:0]] <= byte_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         vld_q      <= 1'b0;
         d_rx_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= wr_d - rd_d;
         vld_q   <= (wr_d != rd_d);
         // Head register follows the new read slot; the incoming byte is
         // forwarded when it lands in that slot this same cycle
         if (push_acc_c || pop_c) begin
            if (push_acc_c && (wr_q[AW-1:0] == rd_d[AW-1:0])) d_rx_q <= byte_q;
            else                                             d_rx_q <= mem_q[rd_d[AW-1:0]];
         end
         if (clr_err) overflow_q <= 1'b0;
         if (drop_c)  overflow_q <= 1'b1;
      end
   end

   assign d_rx      = d_rx_q;
   assign vld_rx    = vld_q;
   assign count     = count_q;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Bench for uart_rx_buf at DIV=16, DEPTH=4: directed scenarios plus random
// frames checked against a byte-queue model of the receive buffer.
module tb_uart_rx_buf;

   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DIV   = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          rxd;
   logic [7:0]    d_rx;
   logic          vld_rx;
   logic          rdy_rx;
   logic [AW:0]   count;
   logic          frame_err;
   logic          overflow;
   logic          clr_err;

   uart_rx_buf #(.CLK_FREQ(16), .BAUD(1), .AW(AW)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .d_rx(d_rx), .vld_rx(vld_rx),
      .rdy_rx(rdy_rx), .count(count), .frame_err(frame_err),
      .overflow(overflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model: bytes held by the buffer and the two sticky flags
   logic [7:0] q_m [$];
   logic       ferr_m, ovf_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"}, 32'(count), 32'(q_m.size()));
      check({tag, ".vld"},   32'(vld_rx), 32'(q_m.size() != 0));
      check({tag, ".ferr"},  32'(frame_err), 32'(ferr_m));
      check({tag, ".ovf"},   32'(overflow), 32'(ovf_m));
      if (q_m.size() != 0) check({tag, ".d_rx"}, 32'(d_rx), 32'(q_m[0]));
   endtask

   // One 8N1 frame, DIV cycles per bit; model updated once the frame is complete
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      idle(DIV);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(DIV);
      end
      rxd = stop;
      idle(DIV);
      rxd = 1'b1;
      if (!stop)                   ferr_m = 1'b1;
      else if (q_m.size() < DEPTH) q_m.push_back(b);
      else                         ovf_m = 1'b1;
   endtask

   task automatic pop_one(input string tag);
      check({tag, ".pop_vld"}, 32'(vld_rx), 32'd1);
      if (q_m.size() != 0) check({tag, ".pop_d"}, 32'(d_rx), 32'(q_m[0]));
      rdy_rx = 1'b1;
      idle(1);
      rdy_rx = 1'b0;
      if (q_m.size() != 0) void'(q_m.pop_front());
   endtask

   task automatic clear_flags();
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
      ferr_m = 1'b0;
      ovf_m  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rxd = 1'b1; rdy_rx = 1'b0; clr_err = 1'b0;
      ferr_m = 1'b0; ovf_m = 1'b0;
      idle(3);
      check("rst.d_rx", 32'(d_rx), 32'd0);
      check_state("rst");
      rst = 1'b0;
      idle(5);

      // Single byte, then a single pop
      send_frame(8'h52, 1'b1);
      idle(3);
      check_state("t1");
      pop_one("t1");
      check_state("t1_after");

      // Short glitch is a false start, next frame still arrives
      rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      idle(40);
      check_state("t2_glitch");
      send_frame(8'h47, 1'b1);
      idle(3);
      check_state("t2");
      pop_one("t2");

      // Bad stop bit
      send_frame(8'hA5, 1'b0);
      idle(3);
      check_state("t3");
      clear_flags();
      check_state("t3_clr");

      // Five back-to-back bytes into a 4-deep buffer
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      idle(3);
      check_state("t4");
      for (int i = 0; i < 4; i++) pop_one("t4_drain");
      check_state("t4_empty");
      clear_flags();

      // Full buffer with a pop on the exact push cycle of the fifth byte:
      // push strobe sits DIV/2 + 9*DIV + 3 cycles after the start bit is driven
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
      fork
         send_frame(8'h05, 1'b1);
         begin
            repeat (DIV / 2 + 9 * DIV + 3) @(posedge clk);
            #1;
            pop_one("t5_simul");
         end
      join
      idle(3);
      check_state("t5");
      for (int i = 0; i < 4; i++) pop_one("t5_drain");
      check_state("t5_empty");

      // Reset in the middle of a frame discards the partial byte
      rxd = 1'b0; idle(DIV);
      rxd = 1'b0; idle(DIV);
      rxd = 1'b0; idle(DIV);
      rxd = 1'b1; idle(DIV / 2);
      rst = 1'b1;
      q_m.delete();
      ferr_m = 1'b0; ovf_m = 1'b0;
      idle(2);
      rst = 1'b0;
      idle(20);
      check_state("t6_rst");
      send_frame(8'h44, 1'b1);
      idle(3);
      check_state("t6");
      pop_one("t6");

      // Random frames, random stop bits, random drains and clears
      for (int n = 0; n < 40; n++) begin
         logic [7:0] b;
         logic       stop;
         b    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         idle($urandom_range(0, 20));
         send_frame(b, stop);
         idle(3);
         check_state("rnd");
         if ($urandom_range(0, 2) == 0) begin
            int k;
            k = $urandom_range(0, q_m.size());
            for (int j = 0; j < k; j++) pop_one("rnd_pop");
            check_state("rnd_drain");
         end
         if ($urandom_range(0, 4) == 0) begin
            clear_flags();
            check_state("rnd_clr");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
